// File: rtl/ps2_keyboard.sv
// ps2_keyboard: receive-only PS/2 keyboard front end with scan-code to ASCII
// translation, modifier/Caps Lock tracking and a 6-digit hex status display.
`default_nettype none

module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [7:0] data,
  output logic [7:0] ascll,
  output logic [2:0] MODEL,
  output logic       ready
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] c_idle_max = IW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_prev;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_frame;
  logic [IW-1:0] r_idle;

  logic          r_ext, r_brk, r_shift, r_ctrl, r_alt, r_caps;
  logic [7:0]    r_data, r_ascll, r_cnt;
  logic [2:0]    r_model;
  logic          r_ready;

  logic          w_fall;
  logic          w_frame_ok;
  logic [7:0]    w_byte;
  logic [7:0]    w_lc;
  logic [7:0]    w_sh;
  logic          w_is_letter;
  logic          w_is_digit;
  logic          w_is_shift;
  logic          w_is_caps;
  logic [7:0]    w_ascii;
  logic [2:0]    w_model;

  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_byte = r_frame[8:1];
  // Frame complete on the 11th falling edge: r_frame holds start..parity, stop is on the pin now.
  assign w_frame_ok = w_fall && (r_bit_cnt == 4'd10) && !r_frame[0]
                      && (^r_frame[9:1]) && r_dat_sync[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
      r_bit_cnt  <= '0;
      r_frame    <= '0;
      r_idle     <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DAT};
      r_clk_prev <= r_clk_sync[1];
      if (w_fall) begin
        r_idle <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_frame   <= {r_dat_sync[1], r_frame[9:1]};
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_idle == c_idle_max) begin
          r_bit_cnt <= '0;
          r_idle    <= '0;
        end else begin
          r_idle <= r_idle + IW'(1);
        end
      end
    end
  end

  // US-layout base table: w_lc is the unshifted character, w_sh the shifted one (0 = same).
  always_comb begin
    w_lc = 8'h00;
    w_sh = 8'h00;
    case (w_byte)
      8'h1C: w_lc = "a";  8'h32: w_lc = "b";  8'h21: w_lc = "c";  8'h23: w_lc = "d";
      8'h24: w_lc = "e";  8'h2B: w_lc = "f";  8'h34: w_lc = "g";  8'h33: w_lc = "h";
      8'h43: w_lc = "i";  8'h3B: w_lc = "j";  8'h42: w_lc = "k";  8'h4B: w_lc = "l";
      8'h3A: w_lc = "m";  8'h31: w_lc = "n";  8'h44: w_lc = "o";  8'h4D: w_lc = "p";
      8'h15: w_lc = "q";  8'h2D: w_lc = "r";  8'h1B: w_lc = "s";  8'h2C: w_lc = "t";
      8'h3C: w_lc = "u";  8'h2A: w_lc = "v";  8'h1D: w_lc = "w";  8'h22: w_lc = "x";
      8'h35: w_lc = "y";  8'h1A: w_lc = "z";
      8'h16: begin w_lc = "1"; w_sh = "!"; end
      8'h1E: begin w_lc = "2"; w_sh = "@"; end
      8'h26: begin w_lc = "3"; w_sh = "#"; end
      8'h25: begin w_lc = "4"; w_sh = "$"; end
      8'h2E: begin w_lc = "5"; w_sh = "%"; end
      8'h36: begin w_lc = "6"; w_sh = "^"; end
      8'h3D: begin w_lc = "7"; w_sh = "&"; end
      8'h3E: begin w_lc = "8"; w_sh = "*"; end
      8'h46: begin w_lc = "9"; w_sh = "("; end
      8'h45: begin w_lc = "0"; w_sh = ")"; end
      8'h4E: begin w_lc = 8'h2D; w_sh = 8'h5F; end
      8'h55: begin w_lc = 8'h3D; w_sh = 8'h2B; end
      8'h54: begin w_lc = 8'h5B; w_sh = 8'h7B; end
      8'h5B: begin w_lc = 8'h5D; w_sh = 8'h7D; end
      8'h5D: begin w_lc = 8'h5C; w_sh = 8'h7C; end
      8'h4C: begin w_lc = 8'h3B; w_sh = 8'h3A; end
      8'h52: begin w_lc = 8'h27; w_sh = 8'h22; end
      8'h41: begin w_lc = 8'h2C; w_sh = 8'h3C; end
      8'h49: begin w_lc = 8'h2E; w_sh = 8'h3E; end
      8'h4A: begin w_lc = 8'h2F; w_sh = 8'h3F; end
      8'h0E: begin w_lc = 8'h60; w_sh = 8'h7E; end
      8'h29: w_lc = 8'h20;
      8'h5A: w_lc = 8'h0D;
      8'h66: w_lc = 8'h08;
      8'h0D: w_lc = 8'h09;
      8'h76: w_lc = 8'h1B;
      default: w_lc = 8'h00;
    endcase
  end

  assign w_is_letter = (w_lc >= 8'h61) && (w_lc <= 8'h7A);
  assign w_is_digit  = (w_lc >= 8'h30) && (w_lc <= 8'h39);
  assign w_is_shift  = !r_ext && ((w_byte == 8'h12) || (w_byte == 8'h59));
  assign w_is_caps   = !r_ext && (w_byte == 8'h58);

  always_comb begin
    w_model = 3'd1;
    w_ascii = w_lc;
    if (r_ext) begin
      w_model = 3'd2;
      w_ascii = 8'h00;
    end else if (r_ctrl && w_is_letter) begin
      w_model = 3'd3;
      w_ascii = w_lc & 8'h1F;
    end else if (r_alt && (w_is_letter || w_is_digit)) begin
      w_model = 3'd4;
      w_ascii = w_lc | 8'h80;
    end else if (w_is_letter) begin
      w_ascii = (r_shift ^ r_caps) ? (w_lc & 8'hDF) : w_lc;
    end else if (r_shift && (w_sh != 8'h00)) begin
      w_ascii = w_sh;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_shift <= 1'b0;
      r_ctrl  <= 1'b0;
      r_alt   <= 1'b0;
      r_caps  <= 1'b0;
      r_data  <= '0;
      r_ascll <= '0;
      r_model <= '0;
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_ready <= 1'b0;
      if (w_frame_ok) begin
        if (w_byte == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (w_byte == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (w_is_shift) begin
            r_shift <= ~r_brk;
          end else if (w_byte == 8'h14) begin
            r_ctrl <= ~r_brk;
          end else if (w_byte == 8'h11) begin
            r_alt <= ~r_brk;
          end else if (w_is_caps) begin
            if (!r_brk) r_caps <= ~r_caps;
          end else if (!r_brk) begin
            r_data  <= w_byte;
            r_ascll <= w_ascii;
            r_model <= w_model;
            r_ready <= 1'b1;
            r_cnt   <= r_cnt + 8'd1;
          end
        end
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

  assign HEX0  = hex7(r_data[3:0]);
  assign HEX1  = hex7(r_data[7:4]);
  assign HEX2  = hex7(r_ascll[3:0]);
  assign HEX3  = hex7(r_ascll[7:4]);
  assign HEX4  = hex7(r_cnt[3:0]);
  assign HEX5  = hex7(r_cnt[7:4]);
  assign data  = r_data;
  assign ascll = r_ascll;
  assign MODEL = r_model;
  assign ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed PS/2 frame stimulus against hand-computed key decodes.
`default_nettype none

module tb_ps2_keyboard;

  localparam int TO   = 200;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tb_clk = 1'b1;
  logic       tb_dat = 1'b1;
  wire        ps2_clk_w;
  wire        ps2_dat_w;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [7:0] data, ascll;
  logic [2:0] model;
  logic       ready;
  int         n_chk = 0;
  int         n_pass = 0;
  int         pulses = 0;
  int         p0;

  assign ps2_clk_w = tb_clk;
  assign ps2_dat_w = tb_dat;

  ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
    .data(data), .ascll(ascll), .MODEL(model), .ready(ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ready) pulses++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic ps2_bits(input logic [7:0] b, input int nbits, input bit badpar);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      tb_dat = f[i];
      repeat (HALF) @(negedge clk);
      tb_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      tb_clk = 1'b1;
    end
    @(negedge clk);
    tb_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_bits(b, 11, 1'b0);
    repeat (12) @(negedge clk);
  endtask

  // Stop bit sent by hand to measure pin-edge-to-ready latency and pulse width.
  task automatic send_timed(input logic [7:0] b);
    int lat;
    int hi;
    lat = 0;
    hi  = 0;
    ps2_bits(b, 10, 1'b0);
    tb_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    tb_clk = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ready) begin
        hi++;
        if (lat == 0) lat = k;
      end
    end
    tb_clk = 1'b1;
    repeat (12) @(negedge clk);
    chk("latency_3to4", int'(lat >= 3 && lat <= 4), 1);
    chk("ready_width", hi, 1);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_ascll", ascll, 8'h00);
    chk("rst_model", model, 0);
    chk("rst_ready", ready, 0);
    chk("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h40}});
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_timed(8'h1C);
    chk("a_data", data, 8'h1C);
    chk("a_ascll", ascll, 8'h61);
    chk("a_model", model, 1);
    chk("a_hex0", hex0, 7'h46);
    chk("a_hex1", hex1, 7'h79);
    chk("a_hex2", hex2, 7'h79);
    chk("a_hex3", hex3, 7'h02);
    chk("a_hex4", hex4, 7'h79);
    chk("a_hex5", hex5, 7'h40);

    p0 = pulses;
    send(8'h12); send(8'h1C);
    chk("shift_A", ascll, 8'h41);
    send(8'hF0); send(8'h12); send(8'h1C);
    chk("unshift_a", ascll, 8'h61);
    chk("shift_pulses", pulses - p0, 2);

    p0 = pulses;
    send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_nopulse", pulses - p0, 0);
    send(8'h1C);
    chk("caps_A", ascll, 8'h41);
    send(8'h12); send(8'h16);
    chk("shift_bang", ascll, 8'h21);
    send(8'h1C);
    chk("shift_caps_a", ascll, 8'h61);
    send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58);

    send(8'h14); send(8'h21);
    chk("ctrl_model", model, 3);
    chk("ctrl_c", ascll, 8'h03);
    send(8'h11); send(8'h1C);
    chk("ctrlalt_model", model, 3);
    chk("ctrlalt_a", ascll, 8'h01);
    send(8'hF0); send(8'h14); send(8'h21);
    chk("alt_model", model, 4);
    chk("alt_c", ascll, 8'hE3);
    send(8'hF0); send(8'h11);

    send(8'hE0); send(8'h75);
    chk("ext_model", model, 2);
    chk("ext_ascll", ascll, 8'h00);
    chk("ext_data", data, 8'h75);
    chk("cnt10_hex4", hex4, 7'h08);

    send(8'h5A);
    chk("enter", ascll, 8'h0D);
    send(8'h66);
    chk("bksp", ascll, 8'h08);

    p0 = pulses;
    ps2_bits(8'h1C, 11, 1'b1);
    repeat (12) @(negedge clk);
    chk("badpar_pulse", pulses - p0, 0);
    chk("badpar_ascll", ascll, 8'h08);
    chk("badpar_data", data, 8'h66);

    ps2_bits(8'h1C, 5, 1'b0);
    repeat (TO + 50) @(negedge clk);
    send(8'h29);
    chk("timeout_space", ascll, 8'h20);
    chk("timeout_data", data, 8'h29);
    chk("cnt13_hex4", hex4, 7'h21);
    send(8'h76);
    chk("esc", ascll, 8'h1B);

    ps2_bits(8'h1C, 4, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_ascll", ascll, 8'h00);
    chk("mid_rst_model", model, 0);
    chk("mid_rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h40}});
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulses;
    send(8'h1C);
    chk("post_rst_a", ascll, 8'h61);
    chk("post_rst_pulse", pulses - p0, 1);
    chk("post_rst_hex4", hex4, 7'h79);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
